// File: rtl/dataram_write_arbiter_pkg.sv
// dataram_write_arbiter_pkg
// Shared definitions for the data RAM write-port arbiter:
//   DEF_ADDR_WIDTH / DEF_DATA_WIDTH : default RAM address / word widths
//   guard_state_t                   : starvation guard FSM encoding
//   host_entry_t                    : queued host write record {address, data}
package dataram_write_arbiter_pkg;

  localparam int unsigned DEF_ADDR_WIDTH = 8;
  localparam int unsigned DEF_DATA_WIDTH = 16;

  typedef enum logic [1:0] {
    GUARD_IDLE  = 2'd0,
    GUARD_COUNT = 2'd1,
    GUARD_STALL = 2'd2
  } guard_state_t;

  typedef struct packed {
    logic [DEF_ADDR_WIDTH-1:0] address;
    logic [DEF_DATA_WIDTH-1:0] data;
  } host_entry_t;

endpackage

// File: rtl/dataram_write_arbiter_if.sv
// dataram_write_arbiter_if
// Bundles the core writeback, host write request and RAM write-port signals
// of dataram_write_arbiter.
//   slave  : the arbiter (consumes core/host requests, drives RAM + status)
//   master : the environment (core, host, RAM side)
// Signals:
//   iCoreWriteEnable/iCoreWriteAddress/iCoreDataIn : core writeback
//   iHostValid/iHostAddress/iHostData, oHostReady  : host write handshake
//   oHostWriteDone, oPending                       : host progress status
//   oWriteEnable/oWriteAddress/oDataIn             : RAM write port
//   oCoreStall, oCollision                         : starvation guard status
interface dataram_write_arbiter_if #(
  parameter int unsigned ADDR_WIDTH = 8,
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned FIFO_DEPTH = 4
);

  logic                          iCoreWriteEnable;
  logic [ADDR_WIDTH-1:0]         iCoreWriteAddress;
  logic [DATA_WIDTH-1:0]         iCoreDataIn;
  logic                          iHostValid;
  logic [ADDR_WIDTH-1:0]         iHostAddress;
  logic [DATA_WIDTH-1:0]         iHostData;
  logic                          oHostReady;
  logic                          oHostWriteDone;
  logic [$clog2(FIFO_DEPTH):0]   oPending;
  logic                          oWriteEnable;
  logic [ADDR_WIDTH-1:0]         oWriteAddress;
  logic [DATA_WIDTH-1:0]         oDataIn;
  logic                          oCoreStall;
  logic                          oCollision;

  modport slave (
    input  iCoreWriteEnable, iCoreWriteAddress, iCoreDataIn,
    input  iHostValid, iHostAddress, iHostData,
    output oHostReady, oHostWriteDone, oPending,
    output oWriteEnable, oWriteAddress, oDataIn,
    output oCoreStall, oCollision
  );

  modport master (
    output iCoreWriteEnable, iCoreWriteAddress, iCoreDataIn,
    output iHostValid, iHostAddress, iHostData,
    input  oHostReady, oHostWriteDone, oPending,
    input  oWriteEnable, oWriteAddress, oDataIn,
    input  oCoreStall, oCollision
  );

endinterface

// File: rtl/dataram_write_arbiter_host_write_fifo.sv
// host_write_fifo
// Synchronous FIFO queuing host writes for the data RAM write port.
// Full/empty are derived from the occupancy count; pointers wrap naturally.
// Ports:
//   Clock, Reset     : clock, asynchronous active-high reset
//   push, push_entry : enqueue an entry (ignored when full)
//   pop              : dequeue the head (ignored when empty)
//   head             : current head entry
//   count            : occupancy, 0..DEPTH
//   full, empty      : occupancy flags
module host_write_fifo
  import dataram_write_arbiter_pkg::*;
#(
  parameter int unsigned DEPTH   = 4,
  parameter type         entry_t = host_entry_t
) (
  input  logic                     Clock,
  input  logic                     Reset,
  input  logic                     push,
  input  entry_t                   push_entry,
  input  logic                     pop,
  output entry_t                   head,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int unsigned      PTR_W      = $clog2(DEPTH);
  localparam logic [PTR_W:0]   FULL_COUNT = (PTR_W + 1)'(DEPTH);

  entry_t             mem [DEPTH];
  logic [PTR_W-1:0]   wr_ptr;
  logic [PTR_W-1:0]   rd_ptr;
  logic               push_ok;
  logic               pop_ok;

  assign full    = (count == FULL_COUNT);
  assign empty   = (count == '0);
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;
  assign head    = mem[rd_ptr];

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage carries no reset: contents are only visible through count.
  always_ff @(posedge Clock) begin
    if (push_ok) mem[wr_ptr] <= push_entry;
  end

endmodule

// File: rtl/dataram_write_arbiter.sv
// dataram_write_arbiter
// Shares the single data RAM write port between the core writeback stage and
// a host port. Core writes pass through combinationally and always win; host
// writes are queued and drained into cycles where the core is not writing.
// Optional build macro HOST_STARVE_GUARD_EN adds a starvation guard that
// requests a one-cycle core bubble after STARVE_LIMIT blocked cycles.
// Ports:
//   Clock : system clock, rising edge
//   Reset : asynchronous, active-high
//   bus   : dataram_write_arbiter_if.slave (core, host and RAM port signals)
module dataram_write_arbiter
  import dataram_write_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH   = DEF_ADDR_WIDTH,
  parameter int unsigned DATA_WIDTH   = DEF_DATA_WIDTH,
  parameter int unsigned FIFO_DEPTH   = 4,
  parameter int unsigned STARVE_LIMIT = 8
) (
  input logic                    Clock,
  input logic                    Reset,
  dataram_write_arbiter_if.slave bus
);

  localparam int unsigned      CNT_W      = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(FIFO_DEPTH);

  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
    $error("FIFO_DEPTH must be a power of 2 and at least 2");
  end
  if (STARVE_LIMIT < 1) begin : g_bad_limit
    $error("STARVE_LIMIT must be at least 1");
  end

  typedef struct packed {
    logic [ADDR_WIDTH-1:0] address;
    logic [DATA_WIDTH-1:0] data;
  } entry_t;

  entry_t             push_entry;
  entry_t             head;
  logic [CNT_W-1:0]   pending;
  logic [CNT_W-1:0]   pending_next;
  logic               full;
  logic               empty;
  logic               push;
  logic               pop;
  logic               ready_q;
  logic               done_q;

  assign push       = bus.iHostValid && ready_q && !full;
  assign pop        = !bus.iCoreWriteEnable && !empty;
  assign push_entry = '{address: bus.iHostAddress, data: bus.iHostData};

  host_write_fifo #(
    .DEPTH   (FIFO_DEPTH),
    .entry_t (entry_t)
  ) u_fifo (
    .Clock      (Clock),
    .Reset      (Reset),
    .push       (push),
    .push_entry (push_entry),
    .pop        (pop),
    .head       (head),
    .count      (pending),
    .full       (full),
    .empty      (empty)
  );

  // Write-port select: core first, then FIFO head, else idle with zeros.
  always_comb begin
    bus.oWriteEnable  = 1'b0;
    bus.oWriteAddress = '0;
    bus.oDataIn       = '0;
    if (bus.iCoreWriteEnable) begin
      bus.oWriteEnable  = 1'b1;
      bus.oWriteAddress = bus.iCoreWriteAddress;
      bus.oDataIn       = bus.iCoreDataIn;
    end else if (!empty) begin
      bus.oWriteEnable  = 1'b1;
      bus.oWriteAddress = head.address;
      bus.oDataIn       = head.data;
    end
  end

  // Ready is registered from the post-edge occupancy so it is low exactly
  // while the queue holds FIFO_DEPTH entries (and during reset).
  always_comb begin
    pending_next = pending;
    if (push && !pop)      pending_next = pending + 1'b1;
    else if (pop && !push) pending_next = pending - 1'b1;
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      ready_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      ready_q <= (pending_next != FULL_COUNT);
      done_q  <= pop;
    end
  end

  assign bus.oHostReady     = ready_q;
  assign bus.oHostWriteDone = done_q;
  assign bus.oPending       = pending;

`ifdef HOST_STARVE_GUARD_EN
  localparam int unsigned         STARVE_W    = $clog2(STARVE_LIMIT + 1);
  localparam logic [STARVE_W-1:0] STARVE_LAST = STARVE_W'(STARVE_LIMIT);

  guard_state_t          state;
  guard_state_t          state_next;
  logic [STARVE_W-1:0]   blocked_cnt;
  logic [STARVE_W-1:0]   blocked_cnt_next;
  logic                  blocked;
  logic                  stall;
  logic                  collision_q;

  // The head is blocked whenever something is queued and the core owns the port.
  assign blocked = bus.iCoreWriteEnable && !empty;

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state       <= GUARD_IDLE;
      blocked_cnt <= '0;
      collision_q <= 1'b0;
    end else begin
      state       <= state_next;
      blocked_cnt <= blocked_cnt_next;
      if (stall && bus.iCoreWriteEnable) collision_q <= 1'b1;
    end
  end

  always_comb begin
    state_next       = state;
    blocked_cnt_next = blocked_cnt;
    stall            = 1'b0;
    unique case (state)
      GUARD_IDLE: begin
        if (blocked) begin
          blocked_cnt_next = STARVE_W'(1);
          state_next       = (blocked_cnt_next == STARVE_LAST) ? GUARD_STALL : GUARD_COUNT;
        end
      end
      GUARD_COUNT: begin
        if (blocked) begin
          blocked_cnt_next = blocked_cnt + 1'b1;
          if (blocked_cnt_next == STARVE_LAST) state_next = GUARD_STALL;
        end else begin
          blocked_cnt_next = '0;
          state_next       = GUARD_IDLE;
        end
      end
      GUARD_STALL: begin
        stall            = 1'b1;
        blocked_cnt_next = '0;
        state_next       = GUARD_IDLE;
      end
      default: begin
        blocked_cnt_next = '0;
        state_next       = GUARD_IDLE;
      end
    endcase
  end

  assign bus.oCoreStall = stall;
  assign bus.oCollision = collision_q;
`else
  assign bus.oCoreStall = 1'b0;
  assign bus.oCollision = 1'b0;
`endif

endmodule

// File: tb/tb_dataram_write_arbiter.sv
// tb_dataram_write_arbiter
// Directed self-checking bench for dataram_write_arbiter. Inputs change 1 ns
// after each rising edge and outputs are checked 1 ns later. Guard-specific
// expectations follow HOST_STARVE_GUARD_EN.
module tb_dataram_write_arbiter;

  logic Clock;
  logic Reset;

  int unsigned checks;
  int unsigned errors;

  logic [15:0] ram [256];

  dataram_write_arbiter_if #(
    .ADDR_WIDTH (8),
    .DATA_WIDTH (16),
    .FIFO_DEPTH (4)
  ) bus ();

  dataram_write_arbiter #(
    .ADDR_WIDTH   (8),
    .DATA_WIDTH   (16),
    .FIFO_DEPTH   (4),
    .STARVE_LIMIT (8)
  ) dut (
    .Clock (Clock),
    .Reset (Reset),
    .bus   (bus)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  // Behavioural RAM written from the arbiter's write port.
  always @(posedge Clock) begin
    if (bus.oWriteEnable) ram[bus.oWriteAddress] <= bus.oDataIn;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic set_in(input logic cwe, input logic [7:0] ca, input logic [15:0] cd,
                        input logic hv, input logic [7:0] ha, input logic [15:0] hd);
    bus.iCoreWriteEnable  = cwe;
    bus.iCoreWriteAddress = ca;
    bus.iCoreDataIn       = cd;
    bus.iHostValid        = hv;
    bus.iHostAddress      = ha;
    bus.iHostData         = hd;
    #1;
  endtask

  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  task automatic check_port(input string tag, input logic we, input logic [7:0] a, input logic [15:0] d);
    check_eq({tag, "_we"},   32'(bus.oWriteEnable),  32'(we));
    check_eq({tag, "_addr"}, 32'(bus.oWriteAddress), 32'(a));
    check_eq({tag, "_data"}, 32'(bus.oDataIn),       32'(d));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout at %0t", $time);
    $fatal(1, "bench did not finish");
  end

  initial begin
    checks = 0;
    errors = 0;
    Reset  = 1'b1;
    set_in(1'b0, 8'h00, 16'h0000, 1'b0, 8'h00, 16'h0000);

    // Reset state
    tick();
    tick();
    check_eq("rst_pending",   32'(bus.oPending),       32'd0);
    check_eq("rst_ready",     32'(bus.oHostReady),     32'd0);
    check_eq("rst_done",      32'(bus.oHostWriteDone), 32'd0);
    check_eq("rst_stall",     32'(bus.oCoreStall),     32'd0);
    check_eq("rst_collision", 32'(bus.oCollision),     32'd0);
    check_port("rst_port", 1'b0, 8'h00, 16'h0000);
    Reset = 1'b0;
    tick();
    check_eq("ready_after_rst", 32'(bus.oHostReady), 32'd1);

    // Single host write with idle core
    set_in(1'b0, 8'h00, 16'h0000, 1'b1, 8'h10, 16'h1234);
    check_port("h1_push", 1'b0, 8'h00, 16'h0000);
    tick();
    set_in(1'b0, 8'h00, 16'h0000, 1'b0, 8'h00, 16'h0000);
    check_port("h1_write", 1'b1, 8'h10, 16'h1234);
    check_eq("h1_pending1", 32'(bus.oPending),       32'd1);
    check_eq("h1_done0",    32'(bus.oHostWriteDone), 32'd0);
    tick();
    check_eq("h1_done1",    32'(bus.oHostWriteDone), 32'd1);
    check_eq("h1_pending0", 32'(bus.oPending),       32'd0);
    check_port("h1_idle", 1'b0, 8'h00, 16'h0000);

    // Same-address conflict: core now, host value lands last
    set_in(1'b1, 8'h05, 16'hBEEF, 1'b1, 8'h05, 16'h0001);
    check_port("conf_core", 1'b1, 8'h05, 16'hBEEF);
    tick();
    set_in(1'b0, 8'h00, 16'h0000, 1'b0, 8'h00, 16'h0000);
    check_port("conf_host", 1'b1, 8'h05, 16'h0001);
    tick();
    check_eq("conf_done", 32'(bus.oHostWriteDone), 32'd1);
    check_eq("conf_ram5", 32'(ram[5]),             32'h0001);

    // Fill the queue behind continuous core writes
    for (int i = 0; i < 4; i++) begin
      set_in(1'b1, 8'(8'h20 + i), 16'(16'hC000 + i), 1'b1, 8'(8'h30 + i), 16'(16'hA000 + i));
      check_port("fill_core", 1'b1, 8'(8'h20 + i), 16'(16'hC000 + i));
      tick();
    end
    // An extra request while full must be refused
    set_in(1'b1, 8'h24, 16'hC004, 1'b1, 8'h3F, 16'hDEAD);
    check_eq("full_pending", 32'(bus.oPending),   32'd4);
    check_eq("full_ready",   32'(bus.oHostReady), 32'd0);
    tick();
    set_in(1'b0, 8'h00, 16'h0000, 1'b0, 8'h00, 16'h0000);
    check_eq("full_refused", 32'(bus.oPending),   32'd4);
    check_eq("pop_ready_lo", 32'(bus.oHostReady), 32'd0);
    for (int i = 0; i < 4; i++) begin
      check_port("drain", 1'b1, 8'(8'h30 + i), 16'(16'hA000 + i));
      tick();
      check_eq("drain_ready", 32'(bus.oHostReady), 32'd1);
    end
    check_port("drain_idle", 1'b0, 8'h00, 16'h0000);
    check_eq("drain_pending", 32'(bus.oPending),       32'd0);
    check_eq("drain_done",    32'(bus.oHostWriteDone), 32'd1);

    // Starvation: one entry queued behind continuous core writes
    set_in(1'b1, 8'h50, 16'h0000, 1'b1, 8'h40, 16'h5555);
    tick();
`ifdef HOST_STARVE_GUARD_EN
    for (int i = 1; i <= 8; i++) begin
      set_in(1'b1, 8'h50, 16'(i), 1'b0, 8'h00, 16'h0000);
      check_eq("g1_nostall", 32'(bus.oCoreStall), 32'd0);
      tick();
    end
    set_in(1'b0, 8'h00, 16'h0000, 1'b0, 8'h00, 16'h0000);
    check_eq("g1_stall", 32'(bus.oCoreStall), 32'd1);
    check_port("g1_drain", 1'b1, 8'h40, 16'h5555);
    tick();
    check_eq("g1_stall_off", 32'(bus.oCoreStall),     32'd0);
    check_eq("g1_done",      32'(bus.oHostWriteDone), 32'd1);
    check_eq("g1_collision", 32'(bus.oCollision),     32'd0);
    check_eq("g1_pending",   32'(bus.oPending),       32'd0);

    // Core ignores the stall request
    set_in(1'b1, 8'h50, 16'h0000, 1'b1, 8'h41, 16'h6666);
    tick();
    for (int i = 1; i <= 8; i++) begin
      set_in(1'b1, 8'h50, 16'(i), 1'b0, 8'h00, 16'h0000);
      check_eq("g2_nostall", 32'(bus.oCoreStall), 32'd0);
      tick();
    end
    set_in(1'b1, 8'h51, 16'h7777, 1'b0, 8'h00, 16'h0000);
    check_eq("g2_stall", 32'(bus.oCoreStall), 32'd1);
    check_port("g2_core_wins", 1'b1, 8'h51, 16'h7777);
    tick();
    set_in(1'b0, 8'h00, 16'h0000, 1'b0, 8'h00, 16'h0000);
    check_eq("g2_collision", 32'(bus.oCollision), 32'd1);
    check_port("g2_drain", 1'b1, 8'h41, 16'h6666);
    tick();
    check_eq("g2_done", 32'(bus.oHostWriteDone), 32'd1);
`else
    for (int i = 1; i <= 12; i++) begin
      set_in(1'b1, 8'h50, 16'(i), 1'b0, 8'h00, 16'h0000);
      check_eq("ng_nostall", 32'(bus.oCoreStall), 32'd0);
      check_port("ng_core", 1'b1, 8'h50, 16'(i));
      tick();
    end
    set_in(1'b0, 8'h00, 16'h0000, 1'b0, 8'h00, 16'h0000);
    check_port("ng_drain", 1'b1, 8'h40, 16'h5555);
    tick();
    check_eq("ng_done",      32'(bus.oHostWriteDone), 32'd1);
    check_eq("ng_collision", 32'(bus.oCollision),     32'd0);
    check_eq("ng_pending",   32'(bus.oPending),       32'd0);
`endif

    // Reset with three entries queued
    for (int i = 0; i < 3; i++) begin
      set_in(1'b1, 8'h60, 16'h0000, 1'b1, 8'(8'h70 + i), 16'(16'hB000 + i));
      tick();
    end
    check_eq("pre_rst_pending", 32'(bus.oPending), 32'd3);
    Reset = 1'b1;
    set_in(1'b0, 8'h00, 16'h0000, 1'b0, 8'h00, 16'h0000);
    check_eq("mid_rst_pending",   32'(bus.oPending),   32'd0);
    check_eq("mid_rst_ready",     32'(bus.oHostReady), 32'd0);
    check_eq("mid_rst_collision", 32'(bus.oCollision), 32'd0);
    check_port("mid_rst_port", 1'b0, 8'h00, 16'h0000);
    tick();
    Reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check_port("post_rst_port", 1'b0, 8'h00, 16'h0000);
      check_eq("post_rst_ready", 32'(bus.oHostReady),     32'd1);
      check_eq("post_rst_done",  32'(bus.oHostWriteDone), 32'd0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/dataram_write_arbiter.md
# dataram_write_arbiter

Shares the single write port of the dual-read data RAM between the MiniAlu writeback stage and an external host (loader/debug) port. Core writebacks always win and pass through in the same cycle, so the core's one-deep result forwarding stays valid. Host writes are queued in a small FIFO and drained into idle write-port cycles. An optional starvation guard asks the core to insert a bubble when host traffic waits too long.

## Interface
- ADDR_WIDTH, 8: data RAM address width
- DATA_WIDTH, 16: data RAM word width
- FIFO_DEPTH, 4: host write queue entries; power of 2, ≥2
- STARVE_LIMIT, 8: consecutive blocked cycles before a stall request (guard build only)
- Clock  in  1  system clock, rising edge
- Reset  in  1  asynchronous, active-high
- iCoreWriteEnable  in  1  core writeback valid this cycle
- iCoreWriteAddress  in  ADDR_WIDTH  core destination
- iCoreDataIn  in  DATA_WIDTH  core result
- iHostValid  in  1  host write request
- iHostAddress  in  ADDR_WIDTH  host destination
- iHostData  in  DATA_WIDTH  host data
- oHostReady  out  1  queue can accept a host write
- oHostWriteDone  out  1  one-cycle pulse: a host entry reached RAM
- oPending  out  clog2(FIFO_DEPTH)+1  queued host entries
- oWriteEnable  out  1  to RAM iWriteEnable
- oWriteAddress  out  ADDR_WIDTH  to RAM iWriteAddress
- oDataIn  out  DATA_WIDTH  to RAM iDataIn
- oCoreStall  out  1  request core to issue a NOP; constant 0 without guard
- oCollision  out  1  sticky: core wrote while oCoreStall was high

## Operation
- Port select, combinational: iCoreWriteEnable=1 → RAM gets the core triple. Else FIFO non-empty → RAM gets the FIFO head and the head pops at the edge. Else oWriteEnable=0; address and data are don't-care and driven to 0.
- Host push: accepted at the edge when iHostValid && oHostReady. Entries keep FIFO order.
- oHostReady = !full, registered from the occupancy count. Ready stays low when full, even in a pop cycle; no push-while-full bypass.
- Same-address conflict (core and head target the same address in one cycle): core writes now, host entry writes later. The host value is final. No merging or cancellation.
- oPending: registered occupancy. Push and pop in the same edge leave it unchanged.
- oHostWriteDone: registered. High the cycle after each host pop.
- Pointers: log2(FIFO_DEPTH) bits, natural wrap. Full/empty come from the count, not pointer compare.

## Timing
- Reset (async assert, released synchronous to Clock): FIFO empty, oPending=0, oHostReady=0, oHostWriteDone=0, oCoreStall=0, oCollision=0, guard state IDLE. Queued entries are discarded.
- oHostReady rises on the first edge after reset release.
- Latency:
  - core → RAM: 0 cycles.
  - host push → earliest RAM write: next cycle.
  - oHostWriteDone: 1 cycle after the RAM write.
- Reset mid-drain: the RAM write in progress completes only if its edge precedes the reset assertion. No partial state survives reset.

## Configuration
- HOST_STARVE_GUARD_EN defined:
  - Guard FSM states IDLE, COUNT, STALL.
  - IDLE→COUNT when the FIFO is non-empty and the core writes.
  - COUNT increments each cycle the head is blocked and returns to IDLE on any pop or when the FIFO empties.
  - At STARVE_LIMIT blocked cycles → STALL.
  - STALL drives oCoreStall=1 for exactly one cycle, then → IDLE with the counter cleared.
  - If the core still writes during STALL, the core wins and oCollision sets; only reset clears it.
- HOST_STARVE_GUARD_EN undefined: no FSM or counter is built; oCoreStall=0 and oCollision=0 permanently. The host can starve indefinitely.

## Structure
- Shared package: ADDR_WIDTH/DATA_WIDTH defaults, the guard state encoding (IDLE=2'd0, COUNT=2'd1, STALL=2'd2), and a host-entry record {address, data}.
- One sub-module, `host_write_fifo`: parameterised synchronous FIFO with push, pop, head, count, full, empty.
- Arbitration mux, done pulse and guard FSM stay in the top.

## Test plan
- Idle core; host pushes (0x10, 0x1234) → oWriteEnable=1 with addr 0x10, data 0x1234 the next cycle; oHostWriteDone the cycle after; oPending returns to 0.
- Core writes (0x05, 0xBEEF) while host pushes (0x05, 0x0001) in the same cycle → RAM gets 0xBEEF that cycle and 0x0001 the following cycle; final RAM[5]=0x0001.
- Core writes every cycle; host pushes 4 entries → oPending=4, oHostReady=0. Core stops → four consecutive host writes in push order, and oHostReady returns high.
- Guard build, STARVE_LIMIT=8: core writes continuously with 1 entry queued → oCoreStall pulses once after 8 blocked cycles. Core idles that cycle → entry drains and oCollision stays 0. Repeat with the core writing during the stall → oCollision=1.
- Non-guard build, same stimulus → oCoreStall never asserts and the entry drains only when the core idles.
- Assert Reset with 3 entries queued → oPending=0, oHostReady=0 immediately. No RAM write after release until a new push.
